// File: rtl/score_pkg.sv
// Shared constants and types for the score-to-glyph-address path.
package score_pkg;

    localparam int NUM_DIGITS          = 6;
    localparam int SCORE_MAX           = 999999;
    localparam int BLANK_GLYPH_DEFAULT = 10;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

endpackage

// File: rtl/score_digit_addr_if.sv
// Score input handshake, row input and the six glyph-RAM address outputs.
interface score_digit_addr_if
    import score_pkg::*;
#(
    parameter int SCORE_W       = 20,
    parameter int ROW_W         = 4,
    parameter int ADDRESS_WIDTH = 8
);
    // A score transfers on a rising clk edge where score_valid && score_ready;
    // the source holds score_in/score_valid stable until then. score_done
    // pulses for one cycle when the converted digits are committed.
    logic [SCORE_W-1:0]       score_in;
    logic                     score_valid;
    logic                     score_ready;
    logic                     score_done;
    logic [ROW_W-1:0]         row_in;
    logic [ADDRESS_WIDTH-1:0] addrUnits;
    logic [ADDRESS_WIDTH-1:0] addrTens;
    logic [ADDRESS_WIDTH-1:0] addrHundreds;
    logic [ADDRESS_WIDTH-1:0] addrThousands;
    logic [ADDRESS_WIDTH-1:0] addrTenThousands;
    logic [ADDRESS_WIDTH-1:0] addrHundredThousands;
    state_t                   fsm_state;

    modport master (
        output score_in, score_valid, row_in,
        input  score_ready, score_done, fsm_state,
        input  addrUnits, addrTens, addrHundreds,
        input  addrThousands, addrTenThousands, addrHundredThousands
    );

    modport slave (
        input  score_in, score_valid, row_in,
        output score_ready, score_done, fsm_state,
        output addrUnits, addrTens, addrHundreds,
        output addrThousands, addrTenThousands, addrHundredThousands
    );

endinterface

// File: rtl/bcd_add3_nibble.sv
// One double-dabble correction step: a BCD nibble of 5 or more gets +3.
module bcd_add3_nibble
    import score_pkg::*;
(
    input  digit_t nibble,
    output digit_t adjusted
);

    assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/score_digit_addr.sv
// Binary score -> six BCD digits (double-dabble) -> per-digit glyph-RAM addresses.
// Build option SCORE_LEADING_ZERO_BLANK_EN shows leading zeros above units as BLANK_GLYPH.
module score_digit_addr
    import score_pkg::*;
#(
    parameter int SCORE_W       = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int GLYPH_ROWS    = 16,
    parameter int ROW_W         = 4,
    parameter int BLANK_GLYPH   = BLANK_GLYPH_DEFAULT
) (
    input logic               clk,
    input logic               resetn,
    score_digit_addr_if.slave bus
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

    // Ten digit glyphs plus the blank glyph must fit in the RAM address space.
    if (11 * GLYPH_ROWS > 2 ** ADDRESS_WIDTH) begin : g_addr_check
        $error("glyph RAM too small: 11*GLYPH_ROWS exceeds 2**ADDRESS_WIDTH");
    end
    if (BLANK_GLYPH < 10 || (BLANK_GLYPH + 1) * GLYPH_ROWS > 2 ** ADDRESS_WIDTH) begin : g_blank_check
        $error("BLANK_GLYPH must not alias a digit glyph and must fit the glyph RAM");
    end

    state_t                    state;
    state_t                    state_next;
    logic                      accept;
    logic [SCORE_W-1:0]        shift_q;
    logic [BCD_W-1:0]          scratch_q;
    logic [BCD_W-1:0]          scratch_adj;
    logic [BCD_W+SCORE_W-1:0]  shifted;
    logic [CNT_W-1:0]          cnt_q;
    digit_t                    digit_q   [NUM_DIGITS];
    logic [ADDRESS_WIDTH-1:0]  glyph     [NUM_DIGITS];
    logic [ADDRESS_WIDTH-1:0]  addr_next [NUM_DIGITS];
    logic [ADDRESS_WIDTH-1:0]  addr_q    [NUM_DIGITS];

    assign accept          = (state == IDLE) && bus.score_valid;
    assign bus.score_ready = (state == IDLE);
    assign bus.score_done  = (state == COMMIT);
    assign bus.fsm_state   = state;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
        bcd_add3_nibble u_add3 (
            .nibble   (scratch_q[4*i +: 4]),
            .adjusted (scratch_adj[4*i +: 4])
        );
    end

    assign shifted = {scratch_adj, shift_q} << 1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CONVERT;
            CONVERT: if (cnt_q == '0) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The counter reaching zero marks the SCORE_W-th shift.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
        end else if (accept) begin
            shift_q   <= (32'(bus.score_in) > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : bus.score_in;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(SCORE_W - 1);
        end else if (state == CONVERT) begin
            {scratch_q, shift_q} <= shifted;
            cnt_q                <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
        end else if (state == COMMIT) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= scratch_q[4*i +: 4];
        end
    end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_q;
    logic [NUM_DIGITS-1:0] blank_next;
    logic                  lead_zero;

    // A digit blanks when it and every digit above it are zero; units never blanks.
    always_comb begin
        blank_next = '0;
        lead_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_zero     = lead_zero && (scratch_q[4*i +: 4] == 4'd0);
            blank_next[i] = lead_zero;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               blank_q <= '0;
        else if (state == COMMIT)  blank_q <= blank_next;
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            glyph[i] = blank_q[i] ? ADDRESS_WIDTH'(BLANK_GLYPH) : ADDRESS_WIDTH'(digit_q[i]);
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) glyph[i] = ADDRESS_WIDTH'(digit_q[i]);
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            addr_next[i] = glyph[i] * ADDRESS_WIDTH'(GLYPH_ROWS) + ADDRESS_WIDTH'(bus.row_in);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_DIGITS; i++) addr_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) addr_q[i] <= addr_next[i];
        end
    end

    assign bus.addrUnits            = addr_q[0];
    assign bus.addrTens             = addr_q[1];
    assign bus.addrHundreds         = addr_q[2];
    assign bus.addrThousands        = addr_q[3];
    assign bus.addrTenThousands     = addr_q[4];
    assign bus.addrHundredThousands = addr_q[5];

endmodule
